// File: rtl/kc_ls1u_pkg.sv
// Shared constants and the prefetch entry type for the KC-LS1u fetch stage.
package kc_ls1u_pkg;

  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned INSTR_W = 16;

  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/kc_ls1u_fetch_fifo.sv
// Prefetch FIFO: push/pop/flush, power-of-two depth, head and empty flag held in registers.
module kc_ls1u_fetch_fifo
  import kc_ls1u_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush_i,
  input  logic   push_i,
  input  logic   pop_i,
  input  entry_t data_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t           mem_q [DEPTH];
  entry_t           head_q, head_d;
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, remain;
  logic             empty_q, empty_d;
  logic             do_pop, do_push;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = empty_q;
  assign head_o  = head_q;

  // The head register is refilled from storage, or straight from data_i when
  // the pushed entry becomes the new head, so a single entry never bubbles.
  always_comb begin
    do_pop  = pop_i & ~empty_q;
    do_push = push_i & (~full_o | do_pop);
    remain  = cnt_q - CNT_W'(do_pop);
    rd_d    = rd_q + PTR_W'(do_pop);
    wr_d    = wr_q + PTR_W'(do_push);
    cnt_d   = remain + CNT_W'(do_push);
    head_d  = head_q;
    if (remain != '0) begin
      head_d = mem_q[rd_d];
    end else if (do_push) begin
      head_d = data_i;
    end
    empty_d = (cnt_d == '0);
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      cnt_d   = '0;
      empty_d = 1'b1;
      head_d  = head_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      head_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/kc_ls1u_fetch.sv
// KC-LS1u instruction fetch: PC, enqueue control, redirect flush, prefetch FIFO.
// Optional out-of-range fetch check enabled by defining KC_LS1U_FETCH_BOUNDS_CHK_EN.
module kc_ls1u_fetch
  import kc_ls1u_pkg::*;
#(
  parameter int unsigned       ADDR_W     = kc_ls1u_pkg::ADDR_W,
  parameter int unsigned       INSTR_W    = kc_ls1u_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC   = kc_ls1u_pkg::RESET_PC,
  parameter int unsigned       FIFO_DEPTH = 2,
  parameter int unsigned       MEM_WORDS  = 26
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               fetch_fault
);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_slot_t;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MEM_WORDS == 0) begin : g_bad_cfg
    $error("kc_ls1u_fetch: FIFO_DEPTH must be a power of two >= 2 and MEM_WORDS nonzero");
  end

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;
  logic              deq, enq_req, push, oob;
  logic              fifo_full, fifo_empty;
  fetch_slot_t       slot, head;

`ifdef KC_LS1U_FETCH_BOUNDS_CHK_EN
  assign oob         = (pc_q >= ADDR_W'(MEM_WORDS));
  assign fetch_fault = fault_q;
`else
  assign oob         = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  assign imem_addr = pc_q;
  assign slot      = '{pc: pc_q, instr: imem_instr};
  assign deq       = ~fifo_empty & if_ready;
  assign enq_req   = ~halt & ~fault_q & (~fifo_full | deq) & ~redirect_valid;
  assign push      = enq_req & ~oob;

  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      fault_d = 1'b0;
    end else if (push) begin
      pc_d = pc_q + ADDR_W'(1);
    end else if (enq_req && oob) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  kc_ls1u_fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_slot_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (push),
    .pop_i   (deq),
    .data_i  (slot),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign if_valid = ~fifo_empty;
  assign if_pc    = head.pc;
  assign if_instr = head.instr;

endmodule
